// File: rtl/speech_phoneme_sequencer_pkg.sv
// Shared types and constants for the phoneme sequencer: FSM states, word/phoneme widths,
// and the byte selector used to unpack two phonemes per queued word.
package speech_pkg;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned PHONEME_W = 8;

    localparam logic [PHONEME_W-1:0] PHONEME_SILENCE = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        START,
        PLAY,
        ADVANCE
    } seq_state_t;

    // Byte 0 is spoken first, byte 1 second.
    function automatic logic [PHONEME_W-1:0] pick_phoneme(input logic [WORD_W-1:0] word,
                                                          input logic              sel);
        return sel ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/speech_phoneme_sequencer_if.sv
// CPU write/status bus and speech-generator handshake of the phoneme sequencer.
// slave is the sequencer's view, master is the CPU/generator side.
interface speech_phoneme_sequencer_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic                             wr_en;
    logic [speech_pkg::WORD_W-1:0]    wr_data;
    logic                             flush;
    logic                             phoneme_speech_busy;
    logic [speech_pkg::PHONEME_W-1:0] phoneme_sel;
    logic                             start_phoneme_output;
    logic                             fifo_empty;
    logic                             fifo_full;
    logic [LVL_W-1:0]                 level;
    logic                             playing;
    logic                             done_pulse;
    logic                             overflow;
    logic                             timeout_err;

    modport master (
        output wr_en, wr_data, flush, phoneme_speech_busy,
        input  phoneme_sel, start_phoneme_output, fifo_empty, fifo_full,
               level, playing, done_pulse, overflow, timeout_err
    );

    modport slave (
        input  wr_en, wr_data, flush, phoneme_speech_busy,
        output phoneme_sel, start_phoneme_output, fifo_empty, fifo_full,
               level, playing, done_pulse, overflow, timeout_err
    );

endinterface

// File: rtl/speech_phoneme_sequencer_fifo.sv
// First-word fall-through synchronous FIFO with synchronous clear and occupancy count.
module speech_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/speech_phoneme_sequencer.sv
// Plays queued phoneme words back-to-back on the speech generator, two codes per word,
// skipping silence codes and reporting queue status, overflow and start timeouts.
module speech_phoneme_sequencer
    import speech_pkg::*;
#(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned START_TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    speech_phoneme_sequencer_if.slave   bus
);
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
    localparam int unsigned TO_W   = $clog2(START_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT - 1);

    seq_state_t           state_q, state_d;
    logic [WORD_W-1:0]    hold_q, hold_d;
    logic                 idx_q, idx_d;
    logic [TO_W-1:0]      wait_q, wait_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic                 to_q, to_d;
    logic                 push;
    logic                 pop;
    logic [WORD_W-1:0]    fifo_dout;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [LVL_W-1:0]     fifo_level;
    logic [PHONEME_W-1:0] cur_phoneme;

    assign push        = bus.wr_en && !fifo_full && !bus.flush;
    assign cur_phoneme = pick_phoneme(hold_q, idx_q);

    speech_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.flush),
        .push  (push),
        .pop   (pop),
        .din   (bus.wr_data),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    // Sequencer next-state; flush overrides everything at the end.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        to_d    = to_q;
        pop     = 1'b0;

        if (bus.wr_en && fifo_full) ovf_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = fifo_dout;
                    idx_d   = 1'b0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (cur_phoneme == PHONEME_SILENCE) begin
                    state_d = ADVANCE;
                end else begin
                    wait_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bus.phoneme_speech_busy) begin
                    state_d = PLAY;
                end else if (wait_q == TO_LAST) begin
                    to_d    = 1'b1;
                    state_d = ADVANCE;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end
            PLAY: begin
                if (!bus.phoneme_speech_busy) state_d = ADVANCE;
            end
            ADVANCE: begin
                if (!idx_q) begin
                    idx_d   = 1'b1;
                    state_d = SELECT;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = fifo_dout;
                    idx_d   = 1'b0;
                    state_d = SELECT;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.flush) begin
            state_d = IDLE;
            hold_d  = '0;
            idx_d   = 1'b0;
            wait_d  = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            to_d    = 1'b0;
            pop     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= 1'b0;
            wait_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            to_q    <= to_d;
        end
    end

    assign bus.phoneme_sel          = cur_phoneme;
    assign bus.start_phoneme_output = (state_q == START);
    assign bus.playing              = (state_q != IDLE);
    assign bus.done_pulse           = done_q;
    assign bus.overflow             = ovf_q;
    assign bus.timeout_err          = to_q;
    assign bus.fifo_empty           = fifo_empty;
    assign bus.fifo_full            = fifo_full;
    assign bus.level                = fifo_level;

endmodule

// File: tb/tb_speech_phoneme_sequencer.sv
// Directed bench for speech_phoneme_sequencer with a behavioural speech-generator model.
module tb_speech_phoneme_sequencer;

    localparam int unsigned DEPTH         = 8;
    localparam int unsigned START_TIMEOUT = 32;
    localparam int          PLAY_LEN      = 10;

    typedef enum int {GEN_AUTO, GEN_HIGH, GEN_LOW} gen_mode_t;

    logic clk = 1'b0;
    logic rst;

    speech_phoneme_sequencer_if #(.DEPTH(DEPTH)) bus();

    speech_phoneme_sequencer #(
        .DEPTH         (DEPTH),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Generator model: in AUTO, a start seen while idle makes busy high for PLAY_LEN cycles.
    gen_mode_t gen_mode = GEN_AUTO;
    int        gen_cnt  = 0;

    always @(posedge clk) begin
        #1;
        case (gen_mode)
            GEN_HIGH: begin bus.phoneme_speech_busy = 1'b1; gen_cnt = 0; end
            GEN_LOW:  begin bus.phoneme_speech_busy = 1'b0; gen_cnt = 0; end
            default: begin
                if (gen_cnt != 0) begin
                    gen_cnt--;
                    bus.phoneme_speech_busy = (gen_cnt != 0);
                end else if (bus.start_phoneme_output && bus.phoneme_speech_busy !== 1'b1) begin
                    bus.phoneme_speech_busy = 1'b1;
                    gen_cnt = PLAY_LEN;
                end else begin
                    bus.phoneme_speech_busy = 1'b0;
                end
            end
        endcase
    end

    // Monitor: phoneme at each start rise, length of each start run, done pulses.
    logic [7:0] started[$];
    int         start_runs[$];
    int         run_len    = 0;
    int         done_cnt   = 0;
    logic       start_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.start_phoneme_output === 1'b1) begin
            if (!start_prev) started.push_back(bus.phoneme_sel);
            run_len++;
        end else if (start_prev) begin
            start_runs.push_back(run_len);
            run_len = 0;
        end
        start_prev = (bus.start_phoneme_output === 1'b1);
        if (bus.done_pulse === 1'b1) done_cnt++;
    end

    task automatic clr_log();
        @(posedge clk);
        started.delete();
        start_runs.delete();
        done_cnt = 0;
    endtask

    task automatic wr(input logic [15:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.playing === 1'b0 && bus.fifo_empty === 1'b1) && n < max);
        chk({tag, "_complete"}, 32'(n < max), 32'd1);
        @(negedge clk);
    endtask

    function automatic logic [7:0] got_at(input int i);
        return (i < started.size()) ? started[i] : 8'hxx;
    endfunction

    initial begin
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.flush   = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_empty",   32'(bus.fifo_empty),           32'd1);
        chk("rst_full",    32'(bus.fifo_full),            32'd0);
        chk("rst_level",   32'(bus.level),                32'd0);
        chk("rst_sel",     32'(bus.phoneme_sel),          32'h00);
        chk("rst_start",   32'(bus.start_phoneme_output), 32'd0);
        chk("rst_playing", 32'(bus.playing),              32'd0);
        chk("rst_flags",   {29'd0, bus.done_pulse, bus.overflow, bus.timeout_err}, 32'd0);
        rst = 1'b0;
        clr_log();

        // Two-phoneme word: start two edges after the write, low byte first.
        wr(16'h2A15);
        chk("t1_start_e0", 32'(bus.start_phoneme_output), 32'd0);
        @(negedge clk);
        chk("t1_start_e1", 32'(bus.start_phoneme_output), 32'd0);
        chk("t1_playing",  32'(bus.playing),              32'd1);
        @(negedge clk);
        chk("t1_start_e2", 32'(bus.start_phoneme_output), 32'd1);
        chk("t1_sel_first", 32'(bus.phoneme_sel),         32'h15);
        wait_done("t1", 200);
        chk("t1_nstarts", 32'(started.size()), 32'd2);
        chk("t1_ph0",     32'(got_at(0)),      32'h15);
        chk("t1_ph1",     32'(got_at(1)),      32'h2A);
        chk("t1_done",    32'(done_cnt),       32'd1);

        // Silence bytes and an all-zero word are skipped.
        clr_log();
        wr(16'h3300);
        wr(16'h0000);
        wait_done("t2", 200);
        chk("t2_nstarts", 32'(started.size()), 32'd1);
        chk("t2_ph0",     32'(got_at(0)),      32'h33);
        chk("t2_done",    32'(done_cnt),       32'd1);

        // Overflow: generator stuck busy, queue fills, extra write dropped.
        clr_log();
        gen_mode = GEN_HIGH;
        wr(16'h0011);
        repeat (4) @(negedge clk);
        for (int i = 0; i <= int'(DEPTH); i++) begin
            @(negedge clk);
            bus.wr_en   = 1'b1;
            bus.wr_data = (i == int'(DEPTH)) ? 16'hEEEE : {8'(8'h41 + 2*i), 8'(8'h40 + 2*i)};
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
        chk("t3_full",     32'(bus.fifo_full), 32'd1);
        chk("t3_level",    32'(bus.level),     32'(DEPTH));
        chk("t3_overflow", 32'(bus.overflow),  32'd1);
        gen_mode = GEN_AUTO;
        wait_done("t3", 2000);
        chk("t3_nstarts", 32'(started.size()), 32'(2*DEPTH + 1));
        chk("t3_ph_first", 32'(got_at(0)), 32'h11);
        for (int i = 0; i < int'(DEPTH); i++) begin
            chk($sformatf("t3_ph_lo%0d", i), 32'(got_at(1 + 2*i)), 32'(8'h40 + 2*i));
            chk($sformatf("t3_ph_hi%0d", i), 32'(got_at(2 + 2*i)), 32'(8'h41 + 2*i));
        end
        chk("t3_done", 32'(done_cnt), 32'd1);

        // Start timeout: busy never rises; both phonemes time out in turn.
        clr_log();
        gen_mode = GEN_LOW;
        wr(16'h5251);
        chk("t4_to_before", 32'(bus.timeout_err), 32'd0);
        wait_done("t4", 400);
        chk("t4_to_after", 32'(bus.timeout_err), 32'd1);
        chk("t4_nstarts",  32'(started.size()), 32'd2);
        chk("t4_ph0",      32'(got_at(0)),      32'h51);
        chk("t4_ph1",      32'(got_at(1)),      32'h52);
        chk("t4_run0",     32'((start_runs.size() > 0) ? start_runs[0] : -1), 32'(START_TIMEOUT));
        chk("t4_done",     32'(done_cnt),       32'd1);

        // Flush during PLAY with 5 words queued; write in the flush cycle is dropped.
        clr_log();
        gen_mode = GEN_HIGH;
        for (int k = 1; k <= 6; k++) wr(16'(k * 16'h0101));
        chk("t5_level_pre",   32'(bus.level),   32'd5);
        chk("t5_playing_pre", 32'(bus.playing), 32'd1);
        @(negedge clk);
        bus.flush   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 16'h7F7F;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        chk("t5_playing", 32'(bus.playing),     32'd0);
        chk("t5_level",   32'(bus.level),       32'd0);
        chk("t5_empty",   32'(bus.fifo_empty),  32'd1);
        chk("t5_ovf",     32'(bus.overflow),    32'd0);
        chk("t5_to",      32'(bus.timeout_err), 32'd0);
        repeat (3) @(negedge clk);
        chk("t5_level_post",   32'(bus.level),   32'd0);
        chk("t5_playing_post", 32'(bus.playing), 32'd0);
        gen_mode = GEN_AUTO;
        repeat (3) @(negedge clk);

        // Asynchronous reset while in START, then normal playback.
        gen_mode = GEN_LOW;
        wr(16'h0061);
        begin
            int n = 0;
            while (bus.start_phoneme_output !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("t6_reach_start", 32'(n < 20), 32'd1);
        end
        rst = 1'b1;
        #1;
        chk("t6_start",   32'(bus.start_phoneme_output), 32'd0);
        chk("t6_playing", 32'(bus.playing),              32'd0);
        chk("t6_sel",     32'(bus.phoneme_sel),          32'h00);
        chk("t6_empty",   32'(bus.fifo_empty),           32'd1);
        chk("t6_level",   32'(bus.level),                32'd0);
        @(negedge clk);
        rst = 1'b0;
        gen_mode = GEN_AUTO;
        clr_log();
        wr(16'h0077);
        wait_done("t6", 200);
        chk("t6_nstarts", 32'(started.size()), 32'd1);
        chk("t6_ph0",     32'(got_at(0)),      32'h77);
        chk("t6_done",    32'(done_cnt),       32'd1);
        chk("t6_to",      32'(bus.timeout_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
